gpu_port_arbiter: RTL and testbench

GPU_PORT_ARBITER -- requirements
Module: gpu_port_arbiter

---
 rtl/gpu_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_gpu_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_port_arbiter.sv
// Purpose: two-requester arbiter onto a single GPU port (registered write issue, pipelined read return); optional stats via GPU_ARB_STATS_EN.
// Latency: write issued on the GPU port 1 cycle after accept; read data returned to the requester 3 cycles after accept.
// Backpressure: readyN is combinational (grant & valid); one accept per cycle, burst-limited to MAX_BURST while the other side waits.
module gpu_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0Valid,
    output logic                  req0Ready,
    input  logic                  req0Write,
    input  logic [ADDR_WIDTH-1:0] req0Addr,
    input  logic [3:0]            req0Strb,
    input  logic [31:0]           req0WData,
    output logic                  rsp0Valid,
    output logic [31:0]           rsp0RData,
    input  logic                  req1Valid,
    output logic                  req1Ready,
    input  logic                  req1Write,
    input  logic [ADDR_WIDTH-1:0] req1Addr,
    input  logic [3:0]            req1Strb,
    input  logic [31:0]           req1WData,
    output logic                  rsp1Valid,
    output logic [31:0]           rsp1RData,
    output logic [ADDR_WIDTH-1:0] gpuAddrIn,
    output logic [3:0]            gpuSizeDecode,
    output logic [31:0]           gpuDataIn,
    output logic [ADDR_WIDTH-1:0] gpuAddrOut,
    input  logic [31:0]           gpuDataOut
`ifdef GPU_ARB_STATS_EN
    ,
    output logic [15:0]           grantCnt0,
    output logic [15:0]           grantCnt1
`endif
);

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    logic                  owner;
    logic [3:0]            burstCnt;
    logic                  winner;
    logic                  accept;
    logic                  selWrite;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [3:0]            selStrb;
    logic [31:0]           selWData;
    logic [2:0]            tagVld;
    logic [2:0]            tagId;

    // Pick the winner. A zero burst count means no burst is in progress, so a
    // tie goes to the requester that did not own last; this is also why owner
    // resets to 1: requester 0 takes the first tie after reset.
    always_comb begin
        winner = req1Valid;
        if (req0Valid && req1Valid) begin
            if ((burstCnt != 4'd0) && (burstCnt < MAXB)) begin
                winner = owner;
            end else begin
                winner = ~owner;
            end
        end
    end

    assign req0Ready = ~rst & req0Valid & ~winner;
    assign req1Ready = ~rst & req1Valid & winner;
    assign accept    = req0Ready | req1Ready;

    assign selWrite = winner ? req1Write : req0Write;
    assign selAddr  = winner ? req1Addr  : req0Addr;
    assign selStrb  = winner ? req1Strb  : req0Strb;
    assign selWData = winner ? req1WData : req0WData;

    // Track ownership and the length of the current burst; an idle cycle ends the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b1;
            burstCnt <= 4'd0;
        end else if (accept) begin
            if (winner != owner) begin
                owner    <= winner;
                burstCnt <= 4'd1;
            end else if (burstCnt < MAXB) begin
                burstCnt <= burstCnt + 4'd1;
            end
        end else begin
            burstCnt <= 4'd0;
        end
    end

    // Issue accepted writes for exactly one cycle; address and data hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpuSizeDecode <= 4'd0;
            gpuAddrIn     <= '0;
            gpuDataIn     <= 32'd0;
        end else begin
            gpuSizeDecode <= 4'd0;
            if (accept && selWrite) begin
                gpuSizeDecode <= selStrb;
                gpuAddrIn     <= selAddr;
                gpuDataIn     <= selWData;
            end
        end
    end

    // Present read addresses and carry a tag per read down a 3-stage pipe:
    // stage 0 = address on the port, stage 1 = GPU data valid, stage 2 = response out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpuAddrOut <= '0;
            tagVld     <= 3'd0;
            tagId      <= 3'd0;
        end else begin
            if (accept && !selWrite) begin
                gpuAddrOut <= selAddr;
            end
            tagVld <= {tagVld[1:0], accept & ~selWrite};
            tagId  <= {tagId[1:0], winner};
        end
    end

    // Capture GPU read data for the originating requester; it holds until that requester's next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0RData <= 32'd0;
            rsp1RData <= 32'd0;
        end else if (tagVld[1]) begin
            if (tagId[1]) begin
                rsp1RData <= gpuDataOut;
            end else begin
                rsp0RData <= gpuDataOut;
            end
        end
    end

    assign rsp0Valid = tagVld[2] & ~tagId[2];
    assign rsp1Valid = tagVld[2] & tagId[2];

`ifdef GPU_ARB_STATS_EN
    // Count accepts per requester, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantCnt0 <= 16'd0;
            grantCnt1 <= 16'd0;
        end else begin
            if (req0Ready && grantCnt0 != 16'hFFFF) begin
                grantCnt0 <= grantCnt0 + 16'd1;
            end
            if (req1Ready && grantCnt1 != 16'hFFFF) begin
                grantCnt1 <= grantCnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpu_port_arbiter.sv
// Purpose: self-checking bench for gpu_port_arbiter (directed table, hand sequences, randomized traffic vs. reference model).
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled inside the same low-activity window.
// Backpressure: requests are presented for one cycle only; the model decides which one is accepted.
module tb_gpu_port_arbiter;

    localparam int AW = 8;
    localparam int MB = 4;
    localparam int NR = 600;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0Valid, req0Ready, req0Write, rsp0Valid;
    logic [AW-1:0] req0Addr;
    logic [3:0]    req0Strb;
    logic [31:0]   req0WData, rsp0RData;
    logic          req1Valid, req1Ready, req1Write, rsp1Valid;
    logic [AW-1:0] req1Addr;
    logic [3:0]    req1Strb;
    logic [31:0]   req1WData, rsp1RData;
    logic [AW-1:0] gpuAddrIn, gpuAddrOut;
    logic [3:0]    gpuSizeDecode;
    logic [31:0]   gpuDataIn, gpuDataOut;
`ifdef GPU_ARB_STATS_EN
    logic [15:0]   grantCnt0, grantCnt1;
`endif

    gpu_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Write(req0Write),
        .req0Addr(req0Addr), .req0Strb(req0Strb), .req0WData(req0WData),
        .rsp0Valid(rsp0Valid), .rsp0RData(rsp0RData),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Write(req1Write),
        .req1Addr(req1Addr), .req1Strb(req1Strb), .req1WData(req1WData),
        .rsp1Valid(rsp1Valid), .rsp1RData(rsp1RData),
        .gpuAddrIn(gpuAddrIn), .gpuSizeDecode(gpuSizeDecode), .gpuDataIn(gpuDataIn),
        .gpuAddrOut(gpuAddrOut), .gpuDataOut(gpuDataOut)
`ifdef GPU_ARB_STATS_EN
        , .grantCnt0(grantCnt0), .grantCnt1(grantCnt1)
`endif
    );

    always #5 clk = ~clk;

    // GPU read model: data for the address shown in one cycle appears in the next.
    logic [31:0] mem [0:255];
    always @(posedge clk) gpuDataOut <= mem[gpuAddrOut];

    int nCmp = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0Valid = 0; req0Write = 0; req0Addr = '0; req0Strb = 0; req0WData = 0;
        req1Valid = 0; req1Write = 0; req1Addr = '0; req1Strb = 0; req1WData = 0;
    endtask

    task automatic set_req(input int n, input logic wr, input logic [AW-1:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        if (n == 0) begin
            req0Valid = 1; req0Write = wr; req0Addr = a; req0Strb = s; req0WData = d;
        end else begin
            req1Valid = 1; req1Write = wr; req1Addr = a; req1Strb = s; req1WData = d;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req0Ready"}, 32'(req0Ready), 0);
        chk({tag, "_req1Ready"}, 32'(req1Ready), 0);
        chk({tag, "_rsp0Valid"}, 32'(rsp0Valid), 0);
        chk({tag, "_rsp1Valid"}, 32'(rsp1Valid), 0);
        chk({tag, "_rsp0RData"}, rsp0RData, 0);
        chk({tag, "_rsp1RData"}, rsp1RData, 0);
        chk({tag, "_gpuAddrIn"}, 32'(gpuAddrIn), 0);
        chk({tag, "_gpuSizeDecode"}, 32'(gpuSizeDecode), 0);
        chk({tag, "_gpuDataIn"}, gpuDataIn, 0);
        chk({tag, "_gpuAddrOut"}, 32'(gpuAddrOut), 0);
    endtask

    // Reset with both requesters asserting, to prove readies are forced low.
    task automatic do_reset;
        rst = 1;
        req0Valid = 1; req1Valid = 1;
        #1;
        check_all_zero("rst_in");
        tick;
        tick;
        check_all_zero("rst_hold");
        idle_inputs();
        rst = 0;
    endtask

    // Reference arbitration: derived from the accept history (-1 = idle cycle).
    int hist[$];
    function automatic int model_winner(input logic v0, input logic v1);
        int last;
        int streak;
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        last = 1;
        streak = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != -1) begin
                last = hist[i];
                break;
            end
        end
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) streak++;
        return (streak > 0 && streak < MB) ? last : 1 - last;
    endfunction

    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } arb_vec_t;

    arb_vec_t tbl [15];

    logic          expWr   [NR+8];
    logic [AW-1:0] expWrA  [NR+8];
    logic [3:0]    expWrS  [NR+8];
    logic [31:0]   expWrD  [NR+8];
    logic          expRd   [NR+8];
    logic [AW-1:0] expRdA  [NR+8];
    logic          expRsp  [NR+8];
    logic          expRspId[NR+8];
    logic [31:0]   expRspD [NR+8];

    initial begin
        logic [AW-1:0] lastWrA, lastRdA;
        logic [31:0]   lastWrD, lastR0, lastR1;
        logic          v0, v1, wr0, wr1;
        logic [AW-1:0] a0, a1;
        logic [3:0]    s0, s1;
        logic [31:0]   d0, d1;
        int            w;

        // Both-valid burst pattern from reset, then owner/idle corner cases.
        tbl[0]  = '{1,1,1,0}; tbl[1]  = '{1,1,1,0}; tbl[2]  = '{1,1,1,0}; tbl[3]  = '{1,1,1,0};
        tbl[4]  = '{1,1,0,1}; tbl[5]  = '{1,1,0,1}; tbl[6]  = '{1,1,0,1}; tbl[7]  = '{1,1,0,1};
        tbl[8]  = '{1,1,1,0}; tbl[9]  = '{0,1,0,1}; tbl[10] = '{0,0,0,0}; tbl[11] = '{1,1,1,0};
        tbl[12] = '{1,0,1,0}; tbl[13] = '{1,1,1,0}; tbl[14] = '{0,1,0,1};

        rst = 1;
        idle_inputs();
        gpuDataOut = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5] = 32'h12345678;
        tick;
        do_reset();

        // Table: arbitration order, zero-strobe writes never pulse the GPU strobe.
        for (int i = 0; i < 15; i++) begin
            idle_inputs();
            if (tbl[i].v0) set_req(0, 1, AW'(i), 4'h0, 32'(i));
            if (tbl[i].v1) set_req(1, 1, AW'(i + 16), 4'h0, 32'(i));
            #1;
            chk($sformatf("tbl%0d_req0Ready", i), 32'(req0Ready), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_req1Ready", i), 32'(req1Ready), 32'(tbl[i].r1));
            tick;
            chk($sformatf("tbl%0d_size0", i), 32'(gpuSizeDecode), 0);
        end
        idle_inputs();

        // Single write issue.
        do_reset();
        set_req(0, 1, 8'h10, 4'hF, 32'hDEADBEEF);
        #1;
        chk("wr_req0Ready", 32'(req0Ready), 1);
        tick;
        idle_inputs();
        chk("wr_gpuAddrIn", 32'(gpuAddrIn), 32'h10);
        chk("wr_gpuSizeDecode", 32'(gpuSizeDecode), 32'hF);
        chk("wr_gpuDataIn", gpuDataIn, 32'hDEADBEEF);
        chk("wr_no_rsp", 32'({rsp0Valid, rsp1Valid}), 0);
        tick;
        chk("wr_size_off", 32'(gpuSizeDecode), 0);
        chk("wr_addr_hold", 32'(gpuAddrIn), 32'h10);

        // Single read from requester 1.
        do_reset();
        set_req(1, 0, 8'h05, 4'h0, 32'h0);
        #1;
        chk("rd_req1Ready", 32'(req1Ready), 1);
        tick;
        idle_inputs();
        chk("rd_gpuAddrOut", 32'(gpuAddrOut), 32'h05);
        chk("rd_t1_rsp", 32'({rsp0Valid, rsp1Valid}), 0);
        tick;
        chk("rd_t2_rsp", 32'({rsp0Valid, rsp1Valid}), 0);
        tick;
        chk("rd_rsp1Valid", 32'(rsp1Valid), 1);
        chk("rd_rsp1RData", rsp1RData, 32'h12345678);
        chk("rd_rsp0Valid", 32'(rsp0Valid), 0);
        tick;
        chk("rd_rsp1_end", 32'(rsp1Valid), 0);
        chk("rd_rsp1_hold", rsp1RData, 32'h12345678);

        // Back-to-back reads from alternating requesters.
        do_reset();
        set_req(0, 0, 8'h01, 4'h0, 32'h0);
        #1; chk("alt0_ready", 32'(req0Ready), 1);
        tick; idle_inputs();
        set_req(1, 0, 8'h02, 4'h0, 32'h0);
        #1; chk("alt1_ready", 32'(req1Ready), 1);
        tick; idle_inputs();
        set_req(0, 0, 8'h03, 4'h0, 32'h0);
        #1; chk("alt2_ready", 32'(req0Ready), 1);
        tick; idle_inputs();
        chk("alt_t3_v", 32'({rsp0Valid, rsp1Valid}), 32'b10);
        chk("alt_t3_d", rsp0RData, mem[1]);
        tick;
        chk("alt_t4_v", 32'({rsp0Valid, rsp1Valid}), 32'b01);
        chk("alt_t4_d", rsp1RData, mem[2]);
        tick;
        chk("alt_t5_v", 32'({rsp0Valid, rsp1Valid}), 32'b10);
        chk("alt_t5_d", rsp0RData, mem[3]);
        tick;
        chk("alt_t6_v", 32'({rsp0Valid, rsp1Valid}), 0);

        // Reset in the cycle after a read accept drops the read.
        do_reset();
        set_req(0, 0, 8'h07, 4'h0, 32'h0);
        tick;
        idle_inputs();
        chk("rstmid_addrOut", 32'(gpuAddrOut), 32'h07);
        rst = 1;
        #1;
        check_all_zero("rstmid");
        tick;
        tick;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rstmid_after%0d_rsp", i), 32'({rsp0Valid, rsp1Valid}), 0);
            chk($sformatf("rstmid_after%0d_size", i), 32'(gpuSizeDecode), 0);
            tick;
        end

        // Randomized traffic against the reference model.
        do_reset();
        hist.delete();
        for (int i = 0; i < NR + 8; i++) begin
            expWr[i] = 0; expWrA[i] = 0; expWrS[i] = 0; expWrD[i] = 0;
            expRd[i] = 0; expRdA[i] = 0; expRsp[i] = 0; expRspId[i] = 0; expRspD[i] = 0;
        end
        lastWrA = 0; lastWrD = 0; lastRdA = 0; lastR0 = 0; lastR1 = 0;
        for (int k = 0; k < NR + 4; k++) begin
            if (expWr[k]) begin
                lastWrA = expWrA[k];
                lastWrD = expWrD[k];
            end
            if (expRd[k]) lastRdA = expRdA[k];
            if (expRsp[k]) begin
                if (expRspId[k]) lastR1 = expRspD[k];
                else             lastR0 = expRspD[k];
            end
            chk($sformatf("rnd%0d_size", k), 32'(gpuSizeDecode), expWr[k] ? 32'(expWrS[k]) : 0);
            chk($sformatf("rnd%0d_addrIn", k), 32'(gpuAddrIn), 32'(lastWrA));
            chk($sformatf("rnd%0d_dataIn", k), gpuDataIn, lastWrD);
            chk($sformatf("rnd%0d_addrOut", k), 32'(gpuAddrOut), 32'(lastRdA));
            chk($sformatf("rnd%0d_rspV", k), 32'({rsp0Valid, rsp1Valid}),
                expRsp[k] ? (expRspId[k] ? 32'b01 : 32'b10) : 0);
            chk($sformatf("rnd%0d_r0", k), rsp0RData, lastR0);
            chk($sformatf("rnd%0d_r1", k), rsp1RData, lastR1);
            idle_inputs();
            if (k < NR) begin
                v0 = ($urandom_range(0, 9) < 7);
                v1 = ($urandom_range(0, 9) < 7);
                wr0 = $urandom_range(0, 1); wr1 = $urandom_range(0, 1);
                a0 = AW'($urandom); a1 = AW'($urandom);
                s0 = 4'($urandom); s1 = 4'($urandom);
                d0 = $urandom; d1 = $urandom;
                if (v0) set_req(0, wr0, a0, s0, d0);
                if (v1) set_req(1, wr1, a1, s1, d1);
                #1;
                w = model_winner(v0, v1);
                chk($sformatf("rnd%0d_rdy0", k), 32'(req0Ready), 32'(w == 0));
                chk($sformatf("rnd%0d_rdy1", k), 32'(req1Ready), 32'(w == 1));
                hist.push_back(w);
                if (w >= 0) begin
                    if ((w == 0 ? wr0 : wr1)) begin
                        expWr[k+1]  = 1;
                        expWrA[k+1] = (w == 0) ? a0 : a1;
                        expWrS[k+1] = (w == 0) ? s0 : s1;
                        expWrD[k+1] = (w == 0) ? d0 : d1;
                    end else begin
                        expRd[k+1]    = 1;
                        expRdA[k+1]   = (w == 0) ? a0 : a1;
                        expRsp[k+3]   = 1;
                        expRspId[k+3] = (w == 1);
                        expRspD[k+3]  = mem[(w == 0) ? a0 : a1];
                    end
                end
            end
            tick;
        end
        idle_inputs();

`ifdef GPU_ARB_STATS_EN
        // Grant counters saturate.
        do_reset();
        chk("stats_rst0", 32'(grantCnt0), 0);
        chk("stats_rst1", 32'(grantCnt1), 0);
        set_req(0, 1, 8'h00, 4'h0, 32'h0);
        repeat (70000) tick;
        idle_inputs();
        chk("stats_cnt0", 32'(grantCnt0), 32'hFFFF);
        chk("stats_cnt1", 32'(grantCnt1), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
